// File: rtl/poly_ram_seq.sv
// Load/readout sequencer for a banked polynomial RAM.
// LOAD writes each incoming row to the same address in every bank; READ streams rows back out
// through a small credit-controlled FIFO that absorbs the BRAM read latency and back-pressure.

`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

module poly_ram_seq #(
  parameter int unsigned COE_WIDTH         = 39,
  parameter int unsigned ADDR_WIDTH        = 9,
  parameter int unsigned NUM_BASE_BANK     = 8,
  parameter int unsigned N_ROWS            = 512,
  parameter int unsigned COMMON_BRAM_DELAY = `COMMON_BRAM_DELAY
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_start,
  input  logic                                rd_start,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  m_data,
  output logic                                m_last,
  output logic                                busy,
  output logic                                load_done,
  output logic [NUM_BASE_BANK-1:0]            ram_wea,
  output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] ram_addra,
  output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  ram_dina,
  output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] ram_addrb,
  input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  ram_doutb
);

  localparam int unsigned RowW      = COE_WIDTH * NUM_BASE_BANK;
  localparam int unsigned CntW      = ADDR_WIDTH + 1;
  localparam int unsigned Dly       = COMMON_BRAM_DELAY;
  localparam int unsigned FifoDepth = COMMON_BRAM_DELAY + 2;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned FcntW     = $clog2(FifoDepth + 1);
  localparam int unsigned OccW      = FcntW + 1;
  localparam logic [CntW-1:0] LastRow = CntW'(N_ROWS - 1);
  localparam logic [CntW-1:0] NumRows = CntW'(N_ROWS);

  typedef enum logic [1:0] {StIdle, StLoad, StRead} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]          wr_cnt_q;
  logic [CntW-1:0]          rd_cnt_q;
  logic [NUM_BASE_BANK-1:0] wea_q;
  logic [ADDR_WIDTH-1:0]    addra_q;
  logic [RowW-1:0]          dina_q;
  logic                     load_done_q;
  logic [ADDR_WIDTH-1:0]    addrb_q;

  // In-flight read tracking: valid bit and last-row tag travel together.
  logic [Dly-1:0] inflight_q;
  logic [Dly-1:0] inflight_last_q;

  logic [RowW-1:0]  fifo_data_q [FifoDepth];
  logic             fifo_last_q [FifoDepth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic            wr_hs;
  logic            wr_last;
  logic            rd_go;
  logic            issue;
  logic [CntW-1:0] issue_row;
  logic [OccW-1:0] occ;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign wr_hs   = (state_q == StLoad) && s_valid;
  assign wr_last = wr_hs && (wr_cnt_q == LastRow);
  // wr_start has priority over rd_start when both arrive in IDLE.
  assign rd_go   = (state_q == StIdle) && rd_start && !wr_start;
  assign push    = inflight_q[Dly-1];
  assign pop     = m_valid && m_ready;

  // Read issue: reads start in the rd_start cycle itself, gated by FIFO credits.
  always_comb begin
    occ = {1'b0, fifo_cnt_q};
    for (int i = 0; i < int'(Dly); i++) begin
      occ = occ + {{FcntW{1'b0}}, inflight_q[i]};
    end
    issue_row = rd_go ? '0 : rd_cnt_q;
    issue     = ((state_q == StRead) || rd_go) && (occ < OccW'(FifoDepth)) &&
                (issue_row < NumRows);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (wr_start)      state_d = StLoad;
        else if (rd_start) state_d = StRead;
      end
      StLoad: if (wr_last) state_d = StIdle;
      StRead: if (pop && m_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Load path: counter and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wea_q       <= '0;
      addra_q     <= '0;
      dina_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && wr_start) wr_cnt_q <= '0;
      else if (wr_hs)                      wr_cnt_q <= wr_cnt_q + CntW'(1);
      wea_q       <= {NUM_BASE_BANK{wr_hs}};
      load_done_q <= wr_last;
      if (wr_hs) begin
        addra_q <= wr_cnt_q[ADDR_WIDTH-1:0];
        dina_q  <= s_data;
      end
    end
  end

  // Read path: address register, counter and latency-matching shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q        <= '0;
      addrb_q         <= '0;
      inflight_q      <= '0;
      inflight_last_q <= '0;
    end else begin
      if (rd_go) rd_cnt_q <= '0;
      if (issue) begin
        rd_cnt_q <= issue_row + CntW'(1);
        addrb_q  <= issue_row[ADDR_WIDTH-1:0];
      end
      for (int i = int'(Dly) - 1; i > 0; i--) begin
        inflight_q[i]      <= inflight_q[i-1];
        inflight_last_q[i] <= inflight_last_q[i-1];
      end
      inflight_q[0]      <= issue;
      inflight_last_q[0] <= issue && (issue_row == LastRow);
    end
  end

  // FIFO occupancy update.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FcntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FcntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Output FIFO: captures ram_doutb when the matching in-flight bit emerges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_doutb;
        fifo_last_q[wr_ptr_q] <= inflight_last_q[Dly-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign s_ready   = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign m_valid   = (fifo_cnt_q != '0);
  assign m_data    = fifo_data_q[rd_ptr_q];
  assign m_last    = m_valid && fifo_last_q[rd_ptr_q];
  assign load_done = load_done_q;
  assign ram_wea   = wea_q;
  assign ram_addra = {NUM_BASE_BANK{addra_q}};
  assign ram_dina  = dina_q;
  assign ram_addrb = {NUM_BASE_BANK{addrb_q}};

endmodule

// File: tb/tb_poly_ram_seq.sv
// Scoreboard bench for poly_ram_seq: small config (2 banks x 8-bit, 8 rows, read delay 2).
// Stimulus pushes expected writes/reads into queues; negedge monitors pop and compare.

module tb_poly_ram_seq;

  localparam int CW  = 8;
  localparam int AW  = 3;
  localparam int NB  = 2;
  localparam int NR  = 8;
  localparam int DLY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_start = 1'b0;
  logic              rd_start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [CW*NB-1:0]  s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [CW*NB-1:0]  m_data;
  logic              m_last;
  logic              busy;
  logic              load_done;
  logic [NB-1:0]     ram_wea;
  logic [AW*NB-1:0]  ram_addra;
  logic [CW*NB-1:0]  ram_dina;
  logic [AW*NB-1:0]  ram_addrb;
  logic [CW*NB-1:0]  ram_doutb;

  poly_ram_seq #(
    .COE_WIDTH        (CW),
    .ADDR_WIDTH       (AW),
    .NUM_BASE_BANK    (NB),
    .N_ROWS           (NR),
    .COMMON_BRAM_DELAY(DLY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_start),
    .rd_start (rd_start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .load_done(load_done),
    .ram_wea  (ram_wea),
    .ram_addra(ram_addra),
    .ram_dina (ram_dina),
    .ram_addrb(ram_addrb),
    .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data valid DLY-1 cycles after ram_addrb shows the address.
  logic [CW-1:0] mem [NB][NR];
  logic [AW-1:0] addr_d1 [NB];
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (ram_wea[k]) mem[k][ram_addra[k*AW +: AW]] <= ram_dina[k*CW +: CW];
      addr_d1[k] <= ram_addrb[k*AW +: AW];
    end
  end
  always_comb begin
    ram_doutb = '0;
    for (int k = 0; k < NB; k++) ram_doutb[k*CW +: CW] = mem[k][addr_d1[k]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW*NB-1:0] row_data(input int r);
    logic [CW*NB-1:0] d;
    for (int k = 0; k < NB; k++) d[k*CW +: CW] = CW'(16 * r + k);
    return d;
  endfunction

  // Scoreboards: write = {addr, data}; read = {last, data}.
  logic [AW+CW*NB-1:0] exp_wr [$];
  logic [CW*NB:0]      exp_rd [$];
  logic [AW+CW*NB-1:0] we;
  logic [CW*NB:0]      re;

  int wr_seen, first_wr_cyc, last_wr_cyc;
  int pop_cnt, first_pop_cyc, last_pop_cyc, first_valid_cyc;
  bit valid_seen, bp_mode, stall_prev;
  logic [CW*NB-1:0] prev_data;
  logic             prev_last;

  // Write-port monitor.
  always @(negedge clk) begin
    if (!rst && ram_wea != '0) begin
      chk("wea_all_banks", 64'(ram_wea), 64'({NB{1'b1}}));
      chk("write_expected", 64'(exp_wr.size() > 0), 64'(1));
      if (exp_wr.size() > 0) begin
        we = exp_wr.pop_front();
        chk("ram_addra", 64'(ram_addra), 64'({NB{we[AW+CW*NB-1 -: AW]}}));
        chk("ram_dina", 64'(ram_dina), 64'(we[CW*NB-1:0]));
        chk("load_done_on_last", 64'(load_done),
            64'(we[AW+CW*NB-1 -: AW] == AW'(NR - 1)));
      end
      if (wr_seen == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_seen++;
    end else if (!rst && load_done) begin
      chk("load_done_without_write", 64'(load_done), 64'(0));
    end
  end

  // Read-stream monitor.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_last, prev_data}));
      if (m_valid && !valid_seen) begin
        valid_seen      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        chk("read_expected", 64'(exp_rd.size() > 0), 64'(1));
        if (exp_rd.size() > 0) begin
          re = exp_rd.pop_front();
          chk("m_data", 64'(m_data), 64'(re[CW*NB-1:0]));
          chk("m_last", 64'(m_last), 64'(re[CW*NB]));
        end
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
      end
      if (bp_mode) chk("fifo_cnt_le4", 64'(dut.fifo_cnt_q <= 4), 64'(1));
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, 64'({s_ready, m_valid, m_last, busy, load_done, ram_wea, ram_addra, ram_dina,
                   ram_addrb}), 64'(0));
  endtask

  task automatic do_load(input int gap, input bit both);
    wr_seen = 0;
    for (int r = 0; r < NR; r++) exp_wr.push_back({AW'(r), row_data(r)});
    wr_start = 1'b1;
    rd_start = both;
    @(posedge clk); #1;
    wr_start = 1'b0;
    rd_start = 1'b0;
    chk("s_ready_in_load", 64'(s_ready), 64'(1));
    chk("busy_in_load", 64'(busy), 64'(1));
    if (both) begin
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      chk("load_kept_after_rd_start", 64'(s_ready), 64'(1));
    end
    for (int r = 0; r < NR; r++) begin
      s_valid = 1'b1;
      s_data  = row_data(r);
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (r == NR - 1) chk("s_ready_after_last", 64'(s_ready), 64'(0));
      else repeat (gap) begin @(posedge clk); #1; end
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("write_count", 64'(wr_seen), 64'(NR));
    chk("write_queue_empty", 64'(exp_wr.size()), 64'(0));
    if (gap == 0) chk("write_span", 64'(last_wr_cyc - first_wr_cyc), 64'(NR - 1));
  endtask

  task automatic do_read(input bit bp, input int target);
    int start;
    int n;
    logic [3:0] pat;
    pat        = 4'b1001;
    pop_cnt    = 0;
    valid_seen = 1'b0;
    for (int r = 0; r < NR; r++) exp_rd.push_back({r == NR - 1, row_data(r)});
    m_ready  = 1'b1;
    rd_start = 1'b1;
    start    = cyc;
    @(posedge clk); #1;
    rd_start = 1'b0;
    bp_mode  = bp;
    n = 0;
    while (pop_cnt < target && n < 200) begin
      if (bp) m_ready = pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    chk("pops_in_time", 64'(pop_cnt), 64'(target));
    m_ready = 1'b1;
    bp_mode = 1'b0;
    if (target == NR) begin
      chk("busy_after_last_pop", 64'(busy), 64'(0));
      chk("read_queue_empty", 64'(exp_rd.size()), 64'(0));
      if (!bp) begin
        chk("first_valid_latency", 64'(first_valid_cyc - start), 64'(1 + DLY));
        chk("row_span", 64'(last_pop_cyc - first_pop_cyc), 64'(NR - 1));
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_load_done", 64'(load_done), 64'(0));
    chk("rst_ram_wea", 64'(ram_wea), 64'(0));
    chk("rst_ram_addra", 64'(ram_addra), 64'(0));
    chk("rst_ram_dina", 64'(ram_dina), 64'(0));
    chk("rst_ram_addrb", 64'(ram_addrb), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(0, 1'b0);            // continuous load
    do_read(1'b0, NR);           // full-rate read
    do_read(1'b1, NR);           // back-pressured read
    do_load(2, 1'b0);            // s_valid every 3rd cycle
    do_load(0, 1'b1);            // wr_start+rd_start together, rd_start during LOAD
    for (int i = 0; i < 4; i++) begin
      chk("no_read_after_dual_start", 64'(m_valid), 64'(0));
      @(posedge clk); #1;
    end

    do_read(1'b0, 3);            // reset mid-read after 3 rows
    rst = 1'b1;
    #1;
    chk_all_zero("mid_read_reset_outputs");
    exp_rd.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("after_reset_release");
    do_read(1'b0, NR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
